// File: rtl/alu_pkg.sv
// Shared opcodes, operation-class constants and FSM states for the ALU execution unit.
package alu_pkg;

  localparam logic [2:0] OPC_B   = 3'b000;
  localparam logic [2:0] OPC_A   = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_SUB = 3'b011;
  localparam logic [2:0] OPC_AND = 3'b100;
  localparam logic [2:0] OPC_OR  = 3'b101;
  localparam logic [2:0] OPC_NOT = 3'b110;
  localparam logic [2:0] OPC_NOP = 3'b111;

  localparam logic [2:0] ALU_RTYPE = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

  typedef struct packed {
    logic [2:0] opc;
    logic       reg_write;
    logic       move;
    logic       illegal;
    logic       is_mul;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one bit of B per cycle, low W bits of the product.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int unsigned CntW = $clog2(W);

  logic [W-1:0]    mcand_q, mplier_q, acc_q, acc_d;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;

  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  // The final step's sum is presented directly so the top can register it on the same edge.
  assign done    = busy_q && (cnt_q == CntW'(W - 1));
  assign product = acc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_exec_unit.sv
// Registered ALU execution unit with valid/ready handshakes and status flags.
// Define ALU_MUL_EN to add the iterative multiplier on func bit 8.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned FUNC_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      result,
  output logic              reg_write,
  output logic              move,
  output logic              zero,
  output logic              ovf,
  output logic              illegal
);

  localparam int unsigned FxW = (FUNC_W > 9) ? FUNC_W : 9;
`ifdef ALU_MUL_EN
  localparam int unsigned LegalBits = 9;
`else
  localparam int unsigned LegalBits = 8;
`endif

  alu_state_e   state_q;
  alu_ctrl_t    ctrl;
  logic [FxW-1:0] func_x;
  logic         onehot, high_bits, accept;
  logic [W-1:0] sum, diff, alu_res;
  logic         alu_ovf;

  assign func_x    = FxW'(func);
  assign onehot    = (func_x != '0) && ((func_x & (func_x - 1'b1)) == '0);
  assign high_bits = |(func_x >> LegalBits);

  always_comb begin
    ctrl = '{opc: OPC_B, reg_write: 1'b1, move: 1'b0, illegal: 1'b0, is_mul: 1'b0};
    case (alu_op)
      ALU_RTYPE: begin
        if (!onehot || high_bits) begin
          ctrl.illegal   = 1'b1;
          ctrl.reg_write = 1'b0;
        end else begin
          unique case (1'b1)
            func_x[0]: ctrl.move = 1'b1;
            func_x[1]: ctrl.opc  = OPC_A;
            func_x[2]: ctrl.opc  = OPC_ADD;
            func_x[3]: ctrl.opc  = OPC_SUB;
            func_x[4]: ctrl.opc  = OPC_AND;
            func_x[5]: ctrl.opc  = OPC_OR;
            func_x[6]: ctrl.opc  = OPC_NOT;
            func_x[7]: begin
              ctrl.opc       = OPC_NOP;
              ctrl.reg_write = 1'b0;
            end
`ifdef ALU_MUL_EN
            func_x[8]: ctrl.is_mul = 1'b1;
`endif
            default: ;
          endcase
        end
      end
      ALU_ADD: ctrl.opc = OPC_ADD;
      ALU_SUB: ctrl.opc = OPC_SUB;
      ALU_AND: ctrl.opc = OPC_AND;
      ALU_OR:  ctrl.opc = OPC_OR;
      default: ctrl.opc = OPC_B;
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (ctrl.opc)
      OPC_B:   alu_res = b;
      OPC_A:   alu_res = a;
      OPC_ADD: begin
        alu_res = sum;
        alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OPC_SUB: begin
        alu_res = diff;
        alu_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OPC_AND: alu_res = a & b;
      OPC_OR:  alu_res = a | b;
      OPC_NOT: alu_res = ~a;
      OPC_NOP: alu_res = '0;
    endcase
    if (ctrl.illegal) begin
      alu_res = '0;
      alu_ovf = 1'b0;
    end
  end

  // Gated by reset so nothing is offered while the unit is held in reset.
  assign in_ready = rst && (state_q == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
  logic         mul_done;
  logic [W-1:0] mul_product;

  alu_mul_iter #(
    .W(W)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && ctrl.is_mul),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .product(mul_product)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      reg_write <= 1'b0;
      move      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !ctrl.is_mul) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        reg_write <= ctrl.reg_write;
        move      <= ctrl.move;
        zero      <= (alu_res == '0);
        ovf       <= alu_ovf;
        illegal   <= ctrl.illegal;
      end
`ifdef ALU_MUL_EN
      else if (accept) begin
        state_q <= MUL;
      end
      if (state_q == MUL && mul_done) begin
        state_q   <= IDLE;
        out_valid <= 1'b1;
        result    <= mul_product;
        reg_write <= 1'b1;
        move      <= 1'b0;
        zero      <= (mul_product == '0);
        ovf       <= 1'b0;
        illegal   <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit at W=8: behavioural model plus scoreboard.
module tb_alu_exec_unit;

  localparam int W      = 8;
  localparam int FUNC_W = 9;
`ifdef ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [2:0]        alu_op;
  logic [FUNC_W-1:0] func;
  logic [W-1:0]      a, b, result;
  logic              reg_write, move, zero, ovf, illegal;

  alu_exec_unit #(
    .W     (W),
    .FUNC_W(FUNC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .func     (func),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .reg_write(reg_write),
    .move     (move),
    .zero     (zero),
    .ovf      (ovf),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] result;
    logic         reg_write, move, zero, ovf, illegal;
    int           due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0, n_pass = 0;
  int   cyc = 0, busy = 0, last_out_cyc = 0;
  logic exp_ready;
  exp_t e_mon;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Result and flags from the operation table; due holds the latency in cycles.
  function automatic exp_t model(input logic [2:0] op, input logic [FUNC_W-1:0] f,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   k, sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    e.result = '0; e.reg_write = 1'b1; e.move = 1'b0; e.ovf = 1'b0; e.illegal = 1'b0; e.due = 1;
    if (op == 3'd0) begin
      k = -1;
      if ($countones(f) == 1)
        for (int i = 0; i < FUNC_W; i++) if (f[i]) k = i;
      if (k == 8 && !MulEn) k = -1;
      case (k)
        0: begin e.result = y; e.move = 1'b1; end
        1: e.result = x;
        2: begin s = sx + sy; e.result = x + y; e.ovf = (s > 127) || (s < -128); end
        3: begin s = sx - sy; e.result = x - y; e.ovf = (s > 127) || (s < -128); end
        4: e.result = x & y;
        5: e.result = x | y;
        6: e.result = ~x;
        7: e.reg_write = 1'b0;
        8: begin e.result = W'(int'(x) * int'(y)); e.due = W + 1; end
        default: begin e.illegal = 1'b1; e.reg_write = 1'b0; end
      endcase
    end else begin
      case (op)
        3'd1: begin s = sx + sy; e.result = x + y; e.ovf = (s > 127) || (s < -128); end
        3'd2: begin s = sx - sy; e.result = x - y; e.ovf = (s > 127) || (s < -128); end
        3'd3: e.result = x & y;
        3'd4: e.result = x | y;
        default: e.result = y;
      endcase
    end
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Compare process: every negedge, against the scoreboard front.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_result", result, 0);
      check("rst_flags", {reg_write, move, zero, ovf, illegal}, 0);
      q.delete();
      busy = 0;
    end else begin
      exp_ready = (busy == 0) && (!out_valid || out_ready);
      check("in_ready", in_ready, exp_ready);
      if (q.size() > 0 && q[0].due <= cyc) begin
        check("out_valid", out_valid, 1);
        check("result", result, q[0].result);
        check("reg_write", reg_write, q[0].reg_write);
        check("move", move, q[0].move);
        check("zero", zero, q[0].zero);
        check("ovf", ovf, q[0].ovf);
        check("illegal", illegal, q[0].illegal);
        if (out_valid && out_ready) begin
          void'(q.pop_front());
          last_out_cyc = cyc;
        end
      end else begin
        check("out_valid_idle", out_valid, 0);
      end
      if (busy > 0) busy--;
      if (in_valid && exp_ready) begin
        e_mon = model(alu_op, func, a, b);
        if (e_mon.due > 1) busy = W;
        e_mon.due = cyc + e_mon.due;
        q.push_back(e_mon);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [FUNC_W-1:0] f,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    int   tries = 0;
    logic acc;
    alu_op = op; func = f; a = x; b = y; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 100);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q.size() > 0 || out_valid) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_timeout", (t < 100), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    exp_t        pe;
    logic [W-1:0] sweep_exp [8];
    int          c0, k0;
    sweep_exp = '{8'h0F, 8'h5A, 8'h69, 8'h4B, 8'h0A, 8'h5F, 8'hA5, 8'h00};

    // Pin the model against hand-computed values.
    for (int i = 0; i < 8; i++) begin
      pe = model(3'd0, FUNC_W'(1) << i, 8'h5A, 8'h0F);
      check("pin_sweep", pe.result, sweep_exp[i]);
    end
    pe = model(3'd1, '0, 8'h7F, 8'h01);
    check("pin_ovf", {pe.result, pe.ovf}, {8'h80, 1'b1});
    pe = model(3'd2, '0, 8'h33, 8'h33);
    check("pin_zero", {pe.result, pe.zero, pe.ovf}, {8'h00, 1'b1, 1'b0});
    pe = model(3'd0, FUNC_W'(3), 8'h12, 8'h34);
    check("pin_illegal", {pe.result, pe.reg_write, pe.illegal}, {8'h00, 1'b0, 1'b1});

    // Reset with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; alu_op = 3'($urandom); func = FUNC_W'($urandom);
      a = W'($urandom); b = W'($urandom); out_ready = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    @(posedge clk);
    #1;

    // Single-op latency, then R-type sweep back-to-back.
    send(3'd0, FUNC_W'(4), 8'h5A, 8'h0F);
    @(negedge clk);
    check("lat1_valid", out_valid, 1);
    check("lat1_result", result, 8'h69);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(3'd0, FUNC_W'(1) << i, 8'h5A, 8'h0F);
    wait_drain();

    // Overflow and zero.
    send(3'd1, '0, 8'h7F, 8'h01);
    send(3'd2, '0, 8'h33, 8'h33);
    wait_drain();

    // Backpressure, then drain-and-accept with back-to-back ops.
    out_ready = 1'b0;
    send(3'd1, '0, 8'h10, 8'h20);
    alu_op = 3'd4; func = '0; a = 8'hF0; b = 8'h0C; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", result, 8'h30);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    c0 = cyc;
    out_ready = 1'b1;
    send(3'd4, '0, 8'hF0, 8'h0C);
    send(3'd5, '0, 8'h11, 8'h22);
    send(3'd1, '0, 8'hFF, 8'h01);
    send(3'd2, '0, 8'h80, 8'h01);
    wait_drain();
    check("b2b_cycles", last_out_cyc - c0, 4);

    // Illegal func encodings.
    send(3'd0, FUNC_W'(3), 8'h12, 8'h34);
    @(negedge clk);
    check("illegal_flag", {illegal, reg_write, result}, {1'b1, 1'b0, 8'h00});
    @(posedge clk);
    #1;
    send(3'd0, '0, 8'h12, 8'h34);
`ifndef ALU_MUL_EN
    send(3'd0, FUNC_W'(9'h100), 8'h0D, 8'h0B);
`endif
    wait_drain();

`ifdef ALU_MUL_EN
    // Multiply latency and result, then abort by reset.
    send(3'd0, FUNC_W'(9'h100), 8'h0D, 8'h0B);
    k0 = cyc - 1;
    for (int t = 0; t < 40 && !out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    check("mul_latency", cyc - k0, W + 1);
    check("mul_result", result, 8'h8F);
    wait_drain();
    send(3'd0, FUNC_W'(9'h100), 8'h0D, 8'h0B);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("mul_abort_no_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(3'd0, FUNC_W'(9'h100), 8'h13, 8'h05);
    send(3'd1, '0, 8'h01, 8'h02);
    wait_drain();
`endif

    send(3'd3, '0, 8'hC3, 8'h5A);
    send(3'd7, '0, 8'h01, 8'hAB);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
